// File: rtl/conv2_buf_3ch.sv
// 3x3 window generator for three 12-bit signed feature-map channels (conv2 input).
// Optional `frame_done` strobe on the last window when CONV2_BUF_FRAME_DONE_EN is defined.
module conv2_buf_3ch #(
  parameter int WIDTH     = 12,
  parameter int HEIGHT    = 12,
  parameter int DATA_BITS = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_in,
  input  logic signed [DATA_BITS-1:0] data_in1,
  input  logic signed [DATA_BITS-1:0] data_in2,
  input  logic signed [DATA_BITS-1:0] data_in3,
  output logic signed [DATA_BITS-1:0] data_out1_0,
  output logic signed [DATA_BITS-1:0] data_out1_1,
  output logic signed [DATA_BITS-1:0] data_out1_2,
  output logic signed [DATA_BITS-1:0] data_out1_3,
  output logic signed [DATA_BITS-1:0] data_out1_4,
  output logic signed [DATA_BITS-1:0] data_out1_5,
  output logic signed [DATA_BITS-1:0] data_out1_6,
  output logic signed [DATA_BITS-1:0] data_out1_7,
  output logic signed [DATA_BITS-1:0] data_out1_8,
  output logic signed [DATA_BITS-1:0] data_out2_0,
  output logic signed [DATA_BITS-1:0] data_out2_1,
  output logic signed [DATA_BITS-1:0] data_out2_2,
  output logic signed [DATA_BITS-1:0] data_out2_3,
  output logic signed [DATA_BITS-1:0] data_out2_4,
  output logic signed [DATA_BITS-1:0] data_out2_5,
  output logic signed [DATA_BITS-1:0] data_out2_6,
  output logic signed [DATA_BITS-1:0] data_out2_7,
  output logic signed [DATA_BITS-1:0] data_out2_8,
  output logic signed [DATA_BITS-1:0] data_out3_0,
  output logic signed [DATA_BITS-1:0] data_out3_1,
  output logic signed [DATA_BITS-1:0] data_out3_2,
  output logic signed [DATA_BITS-1:0] data_out3_3,
  output logic signed [DATA_BITS-1:0] data_out3_4,
  output logic signed [DATA_BITS-1:0] data_out3_5,
  output logic signed [DATA_BITS-1:0] data_out3_6,
  output logic signed [DATA_BITS-1:0] data_out3_7,
  output logic signed [DATA_BITS-1:0] data_out3_8,
  output logic                        valid_out_buf
`ifdef CONV2_BUF_FRAME_DONE_EN
  ,
  output logic                        frame_done
`endif
);

  // Together with the live input pixel this chain spans the 2*WIDTH+3 pixels of a window.
  localparam int DEPTH = 2 * WIDTH + 2;
  localparam int CW    = $clog2(WIDTH);
  localparam int RW    = $clog2(HEIGHT);

  typedef logic signed [DATA_BITS-1:0] pix_t;

  pix_t          line1_p0 [DEPTH];
  pix_t          line2_p0 [DEPTH];
  pix_t          line3_p0 [DEPTH];
  logic [CW-1:0] col_p0;
  logic [RW-1:0] row_p0;

  pix_t win1 [9];
  pix_t win2 [9];
  pix_t win3 [9];

  pix_t tap1_p1 [9];
  pix_t tap2_p1 [9];
  pix_t tap3_p1 [9];
  logic vld_p1;

  logic accept;
  logic at_window;
  logic last_col;
  logic last_row;

  assign accept    = valid_in && !rst;
  assign at_window = (row_p0 >= RW'(2)) && (col_p0 >= CW'(2));
  assign last_col  = (col_p0 == CW'(WIDTH - 1));
  assign last_row  = (row_p0 == RW'(HEIGHT - 1));

  // Stage p0: line buffers and raster position of the pixel being accepted
  always_ff @(posedge clk) begin
    if (accept) begin
      line1_p0[0] <= data_in1;
      line2_p0[0] <= data_in2;
      line3_p0[0] <= data_in3;
      for (int i = 1; i < DEPTH; i++) begin
        line1_p0[i] <= line1_p0[i-1];
        line2_p0[i] <= line2_p0[i-1];
        line3_p0[i] <= line3_p0[i-1];
      end
    end
  end

  // Tap k sits (2-k/3) rows and (2-k%3) columns behind the live pixel.
  for (genvar k = 0; k < 9; k++) begin : g_tap
    localparam int OFF = (2 - k / 3) * WIDTH + (2 - k % 3);
    if (OFF == 0) begin : g_live
      assign win1[k] = data_in1;
      assign win2[k] = data_in2;
      assign win3[k] = data_in3;
    end else begin : g_buf
      assign win1[k] = line1_p0[OFF-1];
      assign win2[k] = line2_p0[OFF-1];
      assign win3[k] = line3_p0[OFF-1];
    end
  end

  // Stage p1: registered window and strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      col_p0  <= '0;
      row_p0  <= '0;
      vld_p1  <= 1'b0;
      tap1_p1 <= '{default: '0};
      tap2_p1 <= '{default: '0};
      tap3_p1 <= '{default: '0};
`ifdef CONV2_BUF_FRAME_DONE_EN
      frame_done <= 1'b0;
`endif
    end else begin
      vld_p1 <= 1'b0;
`ifdef CONV2_BUF_FRAME_DONE_EN
      frame_done <= 1'b0;
`endif
      if (valid_in) begin
        if (at_window) begin
          tap1_p1 <= win1;
          tap2_p1 <= win2;
          tap3_p1 <= win3;
          vld_p1  <= 1'b1;
`ifdef CONV2_BUF_FRAME_DONE_EN
          frame_done <= last_col && last_row;
`endif
        end
        if (last_col) begin
          col_p0 <= '0;
          row_p0 <= last_row ? '0 : row_p0 + RW'(1);
        end else begin
          col_p0 <= col_p0 + CW'(1);
        end
      end
    end
  end

  assign valid_out_buf = vld_p1;

  assign data_out1_0 = tap1_p1[0];
  assign data_out1_1 = tap1_p1[1];
  assign data_out1_2 = tap1_p1[2];
  assign data_out1_3 = tap1_p1[3];
  assign data_out1_4 = tap1_p1[4];
  assign data_out1_5 = tap1_p1[5];
  assign data_out1_6 = tap1_p1[6];
  assign data_out1_7 = tap1_p1[7];
  assign data_out1_8 = tap1_p1[8];
  assign data_out2_0 = tap2_p1[0];
  assign data_out2_1 = tap2_p1[1];
  assign data_out2_2 = tap2_p1[2];
  assign data_out2_3 = tap2_p1[3];
  assign data_out2_4 = tap2_p1[4];
  assign data_out2_5 = tap2_p1[5];
  assign data_out2_6 = tap2_p1[6];
  assign data_out2_7 = tap2_p1[7];
  assign data_out2_8 = tap2_p1[8];
  assign data_out3_0 = tap3_p1[0];
  assign data_out3_1 = tap3_p1[1];
  assign data_out3_2 = tap3_p1[2];
  assign data_out3_3 = tap3_p1[3];
  assign data_out3_4 = tap3_p1[4];
  assign data_out3_5 = tap3_p1[5];
  assign data_out3_6 = tap3_p1[6];
  assign data_out3_7 = tap3_p1[7];
  assign data_out3_8 = tap3_p1[8];

endmodule
